// File: rtl/ecc_scrub_pkg.sv
// Shared types and default sizing for the ECC scrub controller.
package ecc_scrub_pkg;

  localparam int DEF_ADDR_WIDTH     = 10;
  localparam int DEF_DATA_WIDTH     = 64;
  localparam int DEF_ECC_WIDTH      = 8;
  localparam int DEF_SCRUB_INTERVAL = 1024;
  localparam int DEF_SBE_THRESHOLD  = 16;
  localparam int DEF_RSP_TIMEOUT    = 64;
  localparam int DEF_CNT_WIDTH      = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD_REQ,
    RD_WAIT,
    CHECK,
    WR_REQ,
    ADVANCE
  } scrub_state_e;

endpackage

// File: rtl/ecc_encoder.sv
// SEC/DED encoder: extended Hamming code with data in the non-power-of-two
// codeword positions, check bits at the powers of two and one overall parity bit.
module ecc_encoder #(
  parameter int DATA_WIDTH = 64,
  parameter int ECC_WIDTH  = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [ECC_WIDTH-1:0]  ecc
);

  // Data bits covered by Hamming check bit bit_idx.
  function automatic logic [DATA_WIDTH-1:0] check_mask(input int bit_idx);
    int d;
    d = 0;
    check_mask = '0;
    for (int pos = 3; d < DATA_WIDTH; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (((pos >> bit_idx) & 1) != 0) check_mask[d] = 1'b1;
        d++;
      end
    end
  endfunction

  logic [ECC_WIDTH-2:0] ham;

  for (genvar gi = 0; gi < ECC_WIDTH - 1; gi++) begin : g_chk
    localparam logic [DATA_WIDTH-1:0] MASK = check_mask(gi);
    assign ham[gi] = ^(data & MASK);
  end

  assign ecc = {^{data, ham}, ham};

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background ECC scrubber: walks the SRAM, writes back corrected SBE words, flags DBEs.
// Define ECC_SCRUB_ERRLOG_EN to add the first-fault address log (dbe_addr, dbe_addr_vld).
module ecc_scrub_ctrl
  import ecc_scrub_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ECC_WIDTH      = DEF_ECC_WIDTH,
  parameter int SCRUB_INTERVAL = DEF_SCRUB_INTERVAL,
  parameter int SBE_THRESHOLD  = DEF_SBE_THRESHOLD,
  parameter int RSP_TIMEOUT    = DEF_RSP_TIMEOUT,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scrub_en,
  input  logic                  host_busy,
  input  logic                  err_clr,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ECC_WIDTH-1:0]  mem_wecc,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] dec_data,
  input  logic                  dec_sbe,
  input  logic                  dec_dbe,
  output logic [CNT_WIDTH-1:0]  sbe_count,
  output logic [CNT_WIDTH-1:0]  dbe_count,
  output logic                  sbe_irq,
  output logic                  dbe_fault,
  output logic                  pass_done
`ifdef ECC_SCRUB_ERRLOG_EN
  ,
  output logic [ADDR_WIDTH-1:0] dbe_addr,
  output logic                  dbe_addr_vld
`endif
);

  localparam int INTV_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [INTV_W-1:0] INTV_LAST = INTV_W'(SCRUB_INTERVAL - 1);
  localparam int TMO_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RSP_TIMEOUT - 1);
  localparam logic [CNT_WIDTH:0] SBE_THR = (CNT_WIDTH + 1)'(SBE_THRESHOLD);

  scrub_state_e state, state_next;

  logic [ADDR_WIDTH-1:0] addr;
  logic [INTV_W-1:0]     intv_cnt;
  logic [TMO_W-1:0]      tmo_cnt;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_sbe;
  logic                  rd_dbe;
  logic                  sbe_evt;
  logic                  dbe_evt;
  logic                  tmo_evt;
  logic                  fault_evt;
  logic [CNT_WIDTH-1:0]  sbe_inc;
  logic [CNT_WIDTH-1:0]  dbe_inc;

  // Requests are gated combinationally so they drop in the same cycle host_busy rises.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (scrub_en) state_next = WAIT;
      end
      WAIT: begin
        if (!scrub_en)                 state_next = IDLE;
        else if (intv_cnt == INTV_LAST) state_next = RD_REQ;
      end
      RD_REQ: begin
        mem_req = !host_busy;
        if (!host_busy && mem_gnt) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid)               state_next = CHECK;
        else if (tmo_cnt == TMO_LAST) state_next = ADVANCE;
      end
      CHECK: begin
        if (rd_sbe && !rd_dbe) state_next = WR_REQ;
        else                   state_next = ADVANCE;
      end
      WR_REQ: begin
        mem_req = !host_busy;
        mem_we  = !host_busy;
        if (!host_busy && mem_gnt) state_next = ADVANCE;
      end
      ADVANCE: begin
        state_next = scrub_en ? WAIT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign sbe_evt   = (state == CHECK) && rd_sbe && !rd_dbe;
  assign dbe_evt   = (state == CHECK) && rd_dbe;
  assign tmo_evt   = (state == RD_WAIT) && !mem_rvalid && (tmo_cnt == TMO_LAST);
  assign fault_evt = dbe_evt || tmo_evt;
  assign sbe_inc   = (&sbe_count) ? sbe_count : sbe_count + 1'b1;
  assign dbe_inc   = (&dbe_count) ? dbe_count : dbe_count + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      intv_cnt  <= '0;
      tmo_cnt   <= '0;
      rd_data   <= '0;
      rd_sbe    <= 1'b0;
      rd_dbe    <= 1'b0;
      pass_done <= 1'b0;
    end else begin
      state     <= state_next;
      intv_cnt  <= (state == WAIT && state_next == WAIT) ? intv_cnt + 1'b1 : '0;
      tmo_cnt   <= (state == RD_WAIT) ? tmo_cnt + 1'b1 : '0;
      pass_done <= (state == ADVANCE) && (&addr);
      if (state == RD_WAIT && mem_rvalid) begin
        rd_data <= dec_data;
        rd_sbe  <= dec_sbe;
        rd_dbe  <= dec_dbe;
      end
      if (state == ADVANCE) addr <= addr + 1'b1;
    end
  end

  // err_clr takes priority over any increment landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbe_count <= '0;
      dbe_count <= '0;
      sbe_irq   <= 1'b0;
      dbe_fault <= 1'b0;
    end else if (err_clr) begin
      sbe_count <= '0;
      dbe_count <= '0;
      sbe_irq   <= 1'b0;
      dbe_fault <= 1'b0;
    end else begin
      if (sbe_evt) begin
        sbe_count <= sbe_inc;
        if ({1'b0, sbe_inc} >= SBE_THR) sbe_irq <= 1'b1;
      end
      if (dbe_evt)   dbe_count <= dbe_inc;
      if (fault_evt) dbe_fault <= 1'b1;
    end
  end

`ifdef ECC_SCRUB_ERRLOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbe_addr     <= '0;
      dbe_addr_vld <= 1'b0;
    end else if (err_clr) begin
      dbe_addr     <= '0;
      dbe_addr_vld <= 1'b0;
    end else if (fault_evt && !dbe_addr_vld) begin
      dbe_addr     <= addr;
      dbe_addr_vld <= 1'b1;
    end
  end
`endif

  assign mem_addr  = addr;
  assign mem_wdata = rd_data;

  ecc_encoder #(
    .DATA_WIDTH(DATA_WIDTH),
    .ECC_WIDTH (ECC_WIDTH)
  ) u_encoder (
    .data(rd_data),
    .ecc (mem_wecc)
  );

endmodule

// File: doc/ecc_scrub_ctrl.md
Name: ecc_scrub_ctrl

Overview:
Background memory scrubber for the ASIL-B ECC-protected SRAM: periodically walks every address, reads data+ECC, and checks the external SEC/DED decoder result. Writes corrected data back on single-bit errors and flags double-bit errors as safety faults. Yields the memory port to functional traffic and reports error counts to the diagnostics block.

Parameters:
ADDR_WIDTH, 10, memory word-address width (depth = 2**ADDR_WIDTH)
DATA_WIDTH, 64, data word width
ECC_WIDTH, 8, ECC code width (7 Hamming + 1 overall parity)
SCRUB_INTERVAL, 1024, idle cycles between scrub accesses (>=1)
SBE_THRESHOLD, 16, SBE count at which sbe_irq asserts
RSP_TIMEOUT, 64, max cycles from accepted read to mem_rvalid
CNT_WIDTH, 16, width of saturating error counters

Ports:
clk  in  1  system clock (400 MHz)
rst_n  in  1  asynchronous active-low reset
scrub_en  in  1  level enable; 0 parks FSM in IDLE after current access completes
host_busy  in  1  functional master owns the memory port this cycle
err_clr  in  1  pulse: clear counters, sticky flags, log
mem_req  out  1  memory request valid
mem_gnt  in  1  memory accepts request (req&&gnt = handshake)
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_WIDTH  access address
mem_wdata  out  DATA_WIDTH  write-back data
mem_wecc  out  ECC_WIDTH  write-back ECC
mem_rvalid  in  1  read response valid
dec_data  in  DATA_WIDTH  corrected data from external decoder (valid with mem_rvalid)
dec_sbe  in  1  decoder single-bit error
dec_dbe  in  1  decoder double-bit error
sbe_count  out  CNT_WIDTH  saturating SBE count
dbe_count  out  CNT_WIDTH  saturating DBE count
sbe_irq  out  1  sticky, set when sbe_count >= SBE_THRESHOLD
dbe_fault  out  1  sticky safety fault (DBE or response timeout)
pass_done  out  1  one-cycle pulse when the last address completes

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, address=0, interval counter=0, all outputs 0.
- States: IDLE -> WAIT (scrub_en=1). WAIT: count to SCRUB_INTERVAL-1 -> RD_REQ. RD_REQ: assert mem_req, mem_we=0 only while host_busy=0; on mem_gnt -> RD_WAIT. RD_WAIT: on mem_rvalid -> CHECK; timeout counter reaching RSP_TIMEOUT -> set dbe_fault, -> ADVANCE. CHECK (1 cycle): dec_dbe -> dbe_count++, dbe_fault=1, no write, -> ADVANCE; dec_sbe -> sbe_count++, latch dec_data, -> WR_REQ; clean -> ADVANCE. WR_REQ: mem_req=1, mem_we=1, mem_wdata=latched data, mem_wecc=encoder(latched data); wait host_busy=0 and mem_gnt -> ADVANCE. ADVANCE: address++; if address was 2**ADDR_WIDTH-1, wrap to 0 and pulse pass_done; -> WAIT if scrub_en else IDLE.
- dec_sbe and dec_dbe both high: treat as DBE.
- mem_req deasserts in the same cycle host_busy rises; mem_addr/mem_we/mem_wdata are held stable while mem_req=1.
- scrub_en falling mid-access: finish the current read/write-back and ADVANCE, then IDLE. Address is retained, so the next pass resumes there.
- Counters saturate at all-ones. sbe_irq compares after the increment. sbe_irq and dbe_fault are cleared only by err_clr or reset. err_clr coinciding with an increment: clear wins.
- Rising/falling rst_n mid-write: request dropped immediately (async), FSM=IDLE.
- Minimum cycles per clean word: SCRUB_INTERVAL + 3 + memory latency.

Optional Feature:
ECC_SCRUB_ERRLOG_EN: adds output ports dbe_addr [ADDR_WIDTH] and dbe_addr_vld [1]. These capture the address of the first DBE or timeout since the last err_clr and do not overwrite on later faults. Without the macro, the ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Package ecc_scrub_pkg: scrub_state_e enum (IDLE, WAIT, RD_REQ, RD_WAIT, CHECK, WR_REQ, ADVANCE) and the default-width localparams.
- Sub-module: one ecc_encoder instance computing mem_wecc from the latched corrected data. No other hierarchy.

Test Plan:
- SCRUB_INTERVAL=4, ADDR_WIDTH=3, all reads clean -> 8 reads at addr 0..7, no writes, pass_done pulses once after addr 7, then addr wraps to 0.
- SBE at addr 5 (dec_data=64'hDEAD_BEEF_0000_0001) -> one write to addr 5 with that data and encoder ECC, sbe_count=1.
- DBE at addr 2 -> no write, dbe_count=1, dbe_fault=1 (with ERRLOG_EN: dbe_addr=2, a later DBE at 6 leaves it at 2). err_clr -> all cleared.
- host_busy held high for 20 cycles during RD_REQ -> mem_req=0 throughout; the read issues the cycle after host_busy falls, with the address unchanged.
- mem_rvalid never returns, RSP_TIMEOUT=8 -> dbe_fault asserts 8 cycles after grant, FSM advances.
- SBE_THRESHOLD=2, three SBEs -> sbe_irq rises on the 2nd. Force sbe_count to all-ones, another SBE -> count holds.
